// File: rtl/core_pkg.sv
// Shared types and widths for the SFU psum feeder slice.
package core_pkg;
  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int KIJ_BW  = 4;
  localparam int OPIX_BW = 6;

  typedef logic [PSUM_BW*COL-1:0] psum_row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feed_state_e;
endpackage

// File: rtl/sfu_pass_counter.sv
// Nested opix (inner) / kij (outer) counter with first/last/final position flags.
module sfu_pass_counter
  import core_pkg::*;
#(
  parameter int KW = KIJ_BW,
  parameter int PW = OPIX_BW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [KW-1:0] k_i,
  input  logic [PW-1:0] p_i,
  output logic [PW-1:0] opix_o,
  output logic [KW-1:0] kij_o,
  output logic          first_o,
  output logic          last_o,
  output logic          final_o
);
  logic [PW-1:0] opix_q, opix_d;
  logic [KW-1:0] kij_q, kij_d;
  logic          opix_wrap;

  assign opix_wrap = (opix_q == p_i - PW'(1));

  always_comb begin
    opix_d = opix_q;
    kij_d  = kij_q;
    if (clr_i) begin
      opix_d = '0;
      kij_d  = '0;
    end else if (en_i) begin
      if (opix_wrap) begin
        opix_d = '0;
        kij_d  = kij_q + KW'(1);
      end else begin
        opix_d = opix_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opix_q <= '0;
      kij_q  <= '0;
    end else begin
      opix_q <= opix_d;
      kij_q  <= kij_d;
    end
  end

  assign opix_o  = opix_q;
  assign kij_o   = kij_q;
  assign first_o = (kij_q == '0);
  assign last_o  = (kij_q == k_i - KW'(1));
  assign final_o = last_o && opix_wrap;
endmodule

// File: rtl/sfu_psum_feeder.sv
// Drains kij-major psum rows from the OFIFO and strobes them into the SFU with
// opix/first/last tags, two cycles after each read.
module sfu_psum_feeder
  import core_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int kij_bw  = KIJ_BW,
  parameter int opix_bw = OPIX_BW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [kij_bw-1:0]      num_kij,
  input  logic [opix_bw-1:0]     num_opix,
  input  logic                   ofifo_valid,
  output logic                   ofifo_rd,
  input  logic [psum_bw*col-1:0] ofifo_data,
  output logic [psum_bw*col-1:0] psum_out,
  output logic                   acc_o,
  output logic [opix_bw-1:0]     opix_o,
  output logic                   first_o,
  output logic                   last_o,
  output logic                   busy,
  output logic                   done
);
  localparam int STAGES = 2;

  feed_state_e state_q, state_d;

  logic [kij_bw-1:0]      k_q;
  logic [opix_bw-1:0]     p_q;
  logic                   launch, degen;
  logic [opix_bw-1:0]     cnt_opix;
  logic [kij_bw-1:0]      cnt_kij;
  logic                   cnt_first, cnt_last, cnt_final;

  logic [STAGES:1]        vld_pipe_q;
  logic [opix_bw-1:0]     s1_opix_q, s2_opix_q;
  logic                   s1_first_q, s1_last_q, s2_first_q, s2_last_q;
  logic [psum_bw*col-1:0] psum_q;

  assign launch = (state_q == IDLE) && start;
  assign degen  = (num_kij == '0) || (num_opix == '0);

  sfu_pass_counter #(.KW(kij_bw), .PW(opix_bw)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (ofifo_rd),
    .clr_i   (launch),
    .k_i     (k_q),
    .p_i     (p_q),
    .opix_o  (cnt_opix),
    .kij_o   (cnt_kij),
    .first_o (cnt_first),
    .last_o  (cnt_last),
    .final_o (cnt_final)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        k_q <= num_kij;
        p_q <= num_opix;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = degen ? DONE : RUN;
      RUN:     if (ofifo_rd && cnt_final) state_d = FLUSH;
      // Wait for the last word to leave stage 2 before signalling done.
      FLUSH:   if (vld_pipe_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ofifo_rd = (state_q == RUN) && ofifo_valid;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
  end

  // Stage 1 holds tags while the OFIFO returns data; stage 2 aligns both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      s1_opix_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_opix_q  <= '0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      psum_q     <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], ofifo_rd};
      if (ofifo_rd) begin
        s1_opix_q  <= cnt_opix;
        s1_first_q <= cnt_first;
        s1_last_q  <= cnt_last;
      end
      if (vld_pipe_q[1]) begin
        psum_q     <= ofifo_data;
        s2_opix_q  <= s1_opix_q;
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
      end
    end
  end

  assign psum_out = psum_q;
  assign acc_o    = vld_pipe_q[STAGES];
  assign opix_o   = s2_opix_q;
  assign first_o  = s2_first_q;
  assign last_o   = s2_last_q;
endmodule

// File: tb/tb_sfu_psum_feeder.sv
// Directed bench for sfu_psum_feeder: OFIFO model, expected-word scoreboard.
module tb_sfu_psum_feeder;
  import core_pkg::*;

  localparam int W  = PSUM_BW*COL;
  localparam int CW = 192;

  typedef struct {
    psum_row_t          data;
    logic [OPIX_BW-1:0] opix;
    logic               first;
    logic               last;
  } exp_t;

  logic               clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [KIJ_BW-1:0]  num_kij = '0;
  logic [OPIX_BW-1:0] num_opix = '0;
  logic               ofifo_valid, ofifo_rd;
  psum_row_t          ofifo_data = '0;
  psum_row_t          psum_out;
  logic               acc_o, first_o, last_o, busy, done;
  logic [OPIX_BW-1:0] opix_o;

  int checks = 0, errors = 0;
  exp_t      exp_q[$];
  psum_row_t words[$];
  int        rd_cyc[$];
  int rd_idx = 0, wr_cnt = 0, cyc = 0, seq = 0;
  int acc_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0, last_acc_cyc = 0;
  logic gate = 1'b0, flush_req = 1'b0;
  exp_t e_m;

  assign ofifo_valid = gate && (rd_idx < wr_cnt);

  sfu_psum_feeder dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_kij     (num_kij),
    .num_opix    (num_opix),
    .ofifo_valid (ofifo_valid),
    .ofifo_rd    (ofifo_rd),
    .ofifo_data  (ofifo_data),
    .psum_out    (psum_out),
    .acc_o       (acc_o),
    .opix_o      (opix_o),
    .first_o     (first_o),
    .last_o      (last_o),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // OFIFO model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush_req) rd_idx <= wr_cnt;
    else if (ofifo_rd) begin
      ofifo_data <= words[rd_idx];
      rd_idx     <= rd_idx + 1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (ofifo_rd) begin
        rd_cnt++;
        rd_cyc.push_back(cyc);
        check("rd_needs_valid", ofifo_valid, 1);
      end
      if (acc_o) begin
        acc_cnt++;
        last_acc_cyc = cyc;
        check("strobe_expected", (exp_q.size() != 0 && rd_cyc.size() != 0), 1);
        if (exp_q.size() != 0 && rd_cyc.size() != 0) begin
          e_m = exp_q.pop_front();
          check("latency", cyc - rd_cyc.pop_front(), 2);
          check("psum_out", psum_out, e_m.data);
          check("opix_o", opix_o, e_m.opix);
          check("first_o", first_o, e_m.first);
          check("last_o", last_o, e_m.last);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input int p);
    psum_row_t w;
    exp_t      e;
    for (int kij = 0; kij < k; kij++)
      for (int op = 0; op < p; op++) begin
        seq++;
        w = '0;
        for (int l = 0; l < COL; l++) w[l*PSUM_BW +: PSUM_BW] = 16'(seq + l*4096);
        words.push_back(w);
        e.data = w; e.opix = OPIX_BW'(op); e.first = (kij == 0); e.last = (kij == k-1);
        exp_q.push_back(e);
      end
    wr_cnt = words.size();
  endtask

  task automatic pulse_start(input int k, input int p);
    num_kij  = KIJ_BW'(k);
    num_opix = OPIX_BW'(p);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    for (int i = 0; i < max && done !== 1'b1; i++) tick();
    check(tag, done, 1);
    tick();
    tick();
  endtask

  int a0, d0, r0;

  initial begin
    // Reset, then idle
    tick(); tick();
    check("reset_outs", {psum_out, acc_o, opix_o, first_o, last_o, busy, done, ofifo_rd}, '0);
    reset = 1'b1;
    tick(); tick(); tick();
    check("idle_outs", {psum_out, acc_o, opix_o, first_o, last_o, busy, done, ofifo_rd}, '0);
    check("idle_no_rd", rd_cnt, 0);

    // Basic K=3 P=2, FIFO always ready
    gate = 1'b1;
    a0 = acc_cnt; d0 = done_cnt;
    load(3, 2);
    pulse_start(3, 2);
    check("busy_run", busy, 1);
    wait_done("basic_done", 40);
    check("basic_strobes", acc_cnt - a0, 6);
    check("basic_done_cnt", done_cnt - d0, 1);
    check("basic_done_after_last", (done_cyc > last_acc_cyc), 1);
    check("basic_sb_empty", exp_q.size(), 0);
    check("basic_idle", busy, 0);

    // FIFO stall after the second read
    a0 = acc_cnt; d0 = done_cnt;
    load(2, 2);
    pulse_start(2, 2);
    for (int i = 0; i < 20 && rd_idx < rd_cnt - rd_cnt + wr_cnt - 2; i++) tick();
    check("stall_two_reads", wr_cnt - rd_idx, 2);
    gate = 1'b0;
    r0 = rd_cnt;
    tick(); tick();
    a0 = acc_cnt;
    tick(); tick(); tick();
    check("stall_no_rd", rd_cnt - r0, 0);
    check("stall_no_acc", acc_cnt - a0, 0);
    gate = 1'b1;
    wait_done("stall_done", 40);
    check("stall_strobes", acc_cnt - a0, 2);
    check("stall_done_cnt", done_cnt - d0, 1);
    check("stall_sb_empty", exp_q.size(), 0);

    // Degenerate K=0
    r0 = rd_cnt; d0 = done_cnt;
    pulse_start(0, 4);
    for (int i = 0; i < 2 && done !== 1'b1; i++) begin
      check("k0_busy", busy, 1);
      tick();
    end
    check("k0_done", done, 1);
    check("k0_busy_done", busy, 1);
    tick();
    check("k0_idle", busy, 0);
    check("k0_no_rd", rd_cnt - r0, 0);
    tick();
    check("k0_done_cnt", done_cnt - d0, 1);

    // Degenerate K=1: first and last on every word
    a0 = acc_cnt;
    load(1, 3);
    pulse_start(1, 3);
    wait_done("k1_done", 40);
    check("k1_strobes", acc_cnt - a0, 3);
    check("k1_sb_empty", exp_q.size(), 0);

    // Second start mid-pass is ignored
    a0 = acc_cnt; d0 = done_cnt;
    load(2, 2);
    pulse_start(2, 2);
    tick();
    num_kij = KIJ_BW'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_start_done", 40);
    for (int i = 0; i < 8; i++) tick();
    check("busy_start_strobes", acc_cnt - a0, 4);
    check("busy_start_done_cnt", done_cnt - d0, 1);
    check("busy_start_sb_empty", exp_q.size(), 0);

    // Async reset mid-pass
    d0 = done_cnt;
    load(2, 3);
    pulse_start(2, 3);
    tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    check("abort_outs", {psum_out, acc_o, opix_o, first_o, last_o, busy, done, ofifo_rd}, '0);
    exp_q.delete();
    rd_cyc.delete();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick();
    check("abort_no_done", done_cnt - d0, 0);
    a0 = acc_cnt; d0 = done_cnt;
    load(1, 1);
    pulse_start(1, 1);
    wait_done("post_abort_done", 40);
    check("post_abort_strobes", acc_cnt - a0, 1);
    check("post_abort_done_cnt", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
